// File: rtl/uart_defines_pkg.sv
// Shared UART definitions: TX FIFO status masks and TX state encodings.
package uart_defines_pkg;

    localparam logic [3:0] Fifo_Empty = 4'b0001;
    localparam logic [3:0] Fifo_AFull = 4'b0010;
    localparam logic [3:0] Fifo_Full  = 4'b0100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_t;

    function automatic logic fifo_has_data(input logic [3:0] status);
        return (status & Fifo_Empty) == 4'b0000;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last (and next-to-last) cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    output logic Bit_End,
    output logic Bit_Pre_End
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign Bit_End     = (count == LAST);
    assign Bit_Pre_End = (count == PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from a TX FIFO and serialises start, 8 data (LSB first),
// optional parity and 1-2 stop bits onto a registered Tx line.
module uart_tx_serializer
    import uart_defines_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Fifo_Data,
    input  logic [3:0] Fifo_Status,
    output logic       Fifo_Read,
    output logic       Tx,
    output logic       Tx_Busy,
    output logic       Tx_Done
);

    tx_state_t  state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       parity_bit;
    logic       bit_end;
    logic       bit_pre_end;
    logic       baud_clear;
    logic       fifo_ready;
    logic       last_stop;

    assign fifo_ready = fifo_has_data(Fifo_Status);
    assign last_stop  = (STOP_BITS == 1) || stop_idx;

    // Holding the counter clear outside the bit states makes START begin at count 0.
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == WAIT);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .Clear      (baud_clear),
        .Bit_End    (bit_end),
        .Bit_Pre_End(bit_pre_end)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            Tx         <= 1'b1;
            Fifo_Read  <= 1'b0;
            Tx_Busy    <= 1'b0;
            Tx_Done    <= 1'b0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            Fifo_Read <= 1'b0;
            Tx_Done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_ready) begin
                        state     <= FETCH;
                        Fifo_Read <= 1'b1;
                        Tx_Busy   <= 1'b1;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    shift_reg  <= Fifo_Data;
                    parity_bit <= (^Fifo_Data) ^ PARITY_ODD;
                    Tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        Tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                                Tx    <= parity_bit;
                            end else begin
                                state    <= STOP;
                                Tx       <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            Tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        Tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
                STOP: begin
                    // Registered pulse is launched one cycle early to land on the final cycle.
                    if (bit_pre_end && last_stop) begin
                        Tx_Done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else if (fifo_ready) begin
                            state     <= FETCH;
                            Fifo_Read <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            Tx_Busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Tx      <= 1'b1;
                    Tx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: four instances cover default, even/odd parity and two stop bits.
module tb_uart_tx_serializer;
    import uart_defines_pkg::*;

    localparam int CPB = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Fifo_Data = 8'h00;
    logic [1:0] sel = 2'd0;
    logic [3:0] status_v [4];
    wire  [3:0] tx_v, read_v, busy_v, done_v;
    wire        tx_s, read_s, busy_s, done_s;

    int         fifo_count = 0;
    int         reads = 0;
    int         underflow = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];

    always #5 Clk = ~Clk;

    assign tx_s   = tx_v[sel];
    assign read_s = read_v[sel];
    assign busy_s = busy_v[sel];
    assign done_s = done_v[sel];

    // Only the selected instance ever sees a non-empty FIFO.
    for (genvar g = 0; g < 4; g++) begin : g_status
        assign status_v[g] = (sel == 2'(g) && fifo_count != 0) ?
                             ((fifo_count >= 3) ? Fifo_AFull : 4'b0000) : Fifo_Empty;
    end

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) u_def (
        .Clk(Clk), .Reset(Reset), .Fifo_Data(Fifo_Data), .Fifo_Status(status_v[0]),
        .Fifo_Read(read_v[0]), .Tx(tx_v[0]), .Tx_Busy(busy_v[0]), .Tx_Done(done_v[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_even (
        .Clk(Clk), .Reset(Reset), .Fifo_Data(Fifo_Data), .Fifo_Status(status_v[1]),
        .Fifo_Read(read_v[1]), .Tx(tx_v[1]), .Tx_Busy(busy_v[1]), .Tx_Done(done_v[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .Clk(Clk), .Reset(Reset), .Fifo_Data(Fifo_Data), .Fifo_Status(status_v[2]),
        .Fifo_Read(read_v[2]), .Tx(tx_v[2]), .Tx_Busy(busy_v[2]), .Tx_Done(done_v[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_stop2 (
        .Clk(Clk), .Reset(Reset), .Fifo_Data(Fifo_Data), .Fifo_Status(status_v[3]),
        .Fifo_Read(read_v[3]), .Tx(tx_v[3]), .Tx_Busy(busy_v[3]), .Tx_Done(done_v[3]));

    // FIFO model: a pop seen mid-FETCH presents the byte through the following WAIT cycle.
    always @(negedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (read_v[i] === 1'b1) begin
                if (i != int'(sel) || fifo_q.size() == 0) begin
                    underflow++;
                end else begin
                    Fifo_Data = fifo_q.pop_front();
                    fifo_count--;
                    reads++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b, input bit expect_rx);
        fifo_q.push_back(b);
        fifo_count++;
        if (expect_rx) exp_q.push_back(b);
    endtask

    // Leaves the bench at the negedge of the first start-bit cycle.
    task automatic sync_start(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (read_s !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (read_s !== 1'b1) begin
            errors++;
            $display("FAIL %s_fetch: Fifo_Read=%b after %0d cycles, required 1", name, read_s, n);
            return;
        end
        @(negedge Clk);
        checks++;
        if (tx_s !== 1'b1 || read_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: Tx=%b Fifo_Read=%b, required Tx=1 Fifo_Read=0", name, tx_s, read_s);
        end
        @(negedge Clk);
        checks++;
        if (tx_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_start_latency: Tx=%b two cycles after Fifo_Read, required 0", name, tx_s);
        end
        ok = (tx_s === 1'b0);
    endtask

    task automatic run_frame(input string name, input int par_en, input int par_odd, input int stops,
                             output logic par_bit, output int stop_len);
        int         frame_len, shape_err, first_bad, done_cnt, done_at, busy_err, read_err, b, ph;
        logic [7:0] exp_b;
        logic [7:0] rx;
        logic       exp_lvl;
        frame_len = (10 + par_en + stops - 1) * CPB;
        shape_err = 0; first_bad = -1; done_cnt = 0; done_at = -1; busy_err = 0; read_err = 0;
        stop_len  = 0; par_bit = 1'bx; rx = 8'h00;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: expected queue size 0, required >0", name);
            exp_b = 8'h00;
        end else begin
            exp_b = exp_q.pop_front();
        end
        for (int c = 1; c <= frame_len; c++) begin
            b  = (c - 1) / CPB;
            ph = (c - 1) % CPB;
            if (b == 0)                     exp_lvl = 1'b0;
            else if (b <= 8)                exp_lvl = exp_b[b-1];
            else if (b == 9 && par_en != 0) exp_lvl = (^exp_b) ^ (par_odd != 0);
            else                            exp_lvl = 1'b1;
            if (tx_s !== exp_lvl) begin
                shape_err++;
                if (first_bad < 0) first_bad = c;
            end
            if (ph == CPB / 2) begin
                if (b >= 1 && b <= 8)           rx[b-1] = tx_s;
                if (b == 9 && par_en != 0)      par_bit = tx_s;
            end
            if (b >= 9 + par_en && tx_s === 1'b1) stop_len++;
            if (done_s === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (busy_s !== 1'b1) busy_err++;
            if (read_s !== 1'b0) read_err++;
            if (c < frame_len) @(negedge Clk);
        end
        checks++;
        if (shape_err != 0) begin
            errors++;
            $display("FAIL %s_frame_shape: %0d wrong Tx cycles, first at cycle %0d, required 0", name, shape_err, first_bad);
        end
        checks++;
        if (rx !== exp_b) begin
            errors++;
            $display("FAIL %s_rx_byte: got 0x%02h, required 0x%02h", name, rx, exp_b);
        end
        checks++;
        if (done_cnt != 1 || done_at != frame_len) begin
            errors++;
            $display("FAIL %s_tx_done: %0d pulses, last at cycle %0d, required 1 at cycle %0d", name, done_cnt, done_at, frame_len);
        end
        checks++;
        if (busy_err != 0 || read_err != 0) begin
            errors++;
            $display("FAIL %s_busy_read: %0d cycles busy low, %0d cycles read high, required 0 and 0", name, busy_err, read_err);
        end
    endtask

    task automatic check_gap(input string name);
        @(negedge Clk);
        checks++;
        if (read_s !== 1'b1 || tx_s !== 1'b1 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL %s_gap_fetch: Fifo_Read=%b Tx=%b Busy=%b, required 1 1 1", name, read_s, tx_s, busy_s);
        end
        @(negedge Clk);
        checks++;
        if (read_s !== 1'b0 || tx_s !== 1'b1) begin
            errors++;
            $display("FAIL %s_gap_wait: Fifo_Read=%b Tx=%b, required 0 1", name, read_s, tx_s);
        end
        @(negedge Clk);
        checks++;
        if (tx_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_gap_start: Tx=%b, required 0", name, tx_s);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge Clk);
        checks++;
        if (busy_s !== 1'b0 || tx_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: Busy=%b Tx=%b Done=%b, required 0 1 0", name, busy_s, tx_s, done_s);
        end
    endtask

    task automatic test_reset;
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({tx_v, busy_v, done_v, read_v} !== 16'hF000) begin
            errors++;
            $display("FAIL reset_async: tx/busy/done/read=%h, required F000", {tx_v, busy_v, done_v, read_v});
        end
        repeat (3) @(negedge Clk);
        checks++;
        if ({tx_v, busy_v, done_v, read_v} !== 16'hF000) begin
            errors++;
            $display("FAIL reset_hold: tx/busy/done/read=%h, required F000", {tx_v, busy_v, done_v, read_v});
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({tx_v, busy_v, done_v, read_v} !== 16'hF000) begin
            errors++;
            $display("FAIL reset_release: tx/busy/done/read=%h, required F000", {tx_v, busy_v, done_v, read_v});
        end
    endtask

    task automatic test_empty_fifo;
        int read_bad, tx_bad, busy_bad;
        read_bad = 0; tx_bad = 0; busy_bad = 0;
        sel = 2'd0;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (read_v !== 4'h0) read_bad++;
            if (tx_v !== 4'hF)   tx_bad++;
            if (busy_v !== 4'h0) busy_bad++;
        end
        checks++;
        if (read_bad != 0 || tx_bad != 0 || busy_bad != 0) begin
            errors++;
            $display("FAIL empty_fifo: read=%0d tx=%0d busy=%0d bad cycles, required 0 0 0", read_bad, tx_bad, busy_bad);
        end
    endtask

    task automatic test_single_byte;
        bit   ok;
        int   r0, sl;
        logic pb;
        sel = 2'd0;
        r0  = reads;
        push_byte(8'h55, 1'b1);
        sync_start("single", ok);
        if (ok) run_frame("single", 0, 0, 1, pb, sl);
        check_idle("single");
        checks++;
        if (reads - r0 != 1) begin
            errors++;
            $display("FAIL single_reads: %0d Fifo_Read pulses, required 1", reads - r0);
        end
    endtask

    task automatic test_back_to_back;
        bit   ok;
        int   r0, sl;
        logic pb;
        sel = 2'd0;
        r0  = reads;
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        sync_start("b2b", ok);
        if (ok) begin
            run_frame("b2b_0", 0, 0, 1, pb, sl);
            check_gap("b2b_1");
            run_frame("b2b_1", 0, 0, 1, pb, sl);
            check_gap("b2b_2");
            run_frame("b2b_2", 0, 0, 1, pb, sl);
        end
        check_idle("b2b");
        checks++;
        if (reads - r0 != 3) begin
            errors++;
            $display("FAIL b2b_reads: %0d Fifo_Read pulses, required 3", reads - r0);
        end
    endtask

    task automatic test_parity(input logic [1:0] inst, input int odd, input logic exp_par);
        bit   ok;
        int   sl;
        logic pb;
        sel = inst;
        push_byte(8'h07, 1'b1);
        sync_start("parity", ok);
        if (ok) begin
            run_frame("parity", 1, odd, 1, pb, sl);
            checks++;
            if (pb !== exp_par) begin
                errors++;
                $display("FAIL parity_bit(odd=%0d): got %b, required %b", odd, pb, exp_par);
            end
        end
        check_idle("parity");
    endtask

    task automatic test_two_stop_bits;
        bit   ok;
        int   sl;
        logic pb;
        sel = 2'd3;
        push_byte(8'hA3, 1'b1);
        sync_start("stop2", ok);
        if (ok) begin
            run_frame("stop2", 0, 0, 2, pb, sl);
            checks++;
            if (sl != 2 * CPB) begin
                errors++;
                $display("FAIL stop2_length: stop level %0d cycles, required %0d", sl, 2 * CPB);
            end
        end
        check_idle("stop2");
    endtask

    task automatic test_reset_mid_frame;
        bit   ok;
        int   r0, sl;
        logic pb;
        sel = 2'd0;
        r0  = reads;
        push_byte(8'hC3, 1'b0);
        push_byte(8'h5A, 1'b1);
        sync_start("midrst", ok);
        if (ok) begin
            repeat (4 * CPB + CPB / 2 - 1) @(negedge Clk);
            checks++;
            if (tx_s !== 1'b0) begin
                errors++;
                $display("FAIL midrst_bit3: Tx=%b before reset, required 0", tx_s);
            end
            #2 Reset = 1'b1;
            #1;
            checks++;
            if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0 || read_s !== 1'b0) begin
                errors++;
                $display("FAIL midrst_async: Tx=%b Busy=%b Done=%b Read=%b, required 1 0 0 0", tx_s, busy_s, done_s, read_s);
            end
            repeat (3) @(negedge Clk);
            Reset = 1'b0;
            sync_start("midrst_next", ok);
            if (ok) run_frame("midrst_next", 0, 0, 1, pb, sl);
        end
        check_idle("midrst");
        checks++;
        if (reads - r0 != 2) begin
            errors++;
            $display("FAIL midrst_reads: %0d Fifo_Read pulses, required 2", reads - r0);
        end
    endtask

    initial begin
        test_reset();
        test_empty_fifo();
        test_single_byte();
        test_back_to_back();
        test_parity(2'd1, 0, 1'b1);
        test_parity(2'd2, 1, 1'b0);
        test_two_stop_bits();
        test_reset_mid_frame();
        checks++;
        if (underflow != 0) begin
            errors++;
            $display("FAIL read_when_empty: %0d pops with empty FIFO or wrong instance, required 0", underflow);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d bytes never received, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
